// File: rtl/seq_ctrl.sv
// seq_ctrl: program sequencer and pipeline controller (fetch PC, loop-call hardware, RAW stalls, squash, writeback enables).
// Optional operand forwarding is enabled with SEQ_CTRL_FWD_EN (adds fwd_a/fwd_b, removes RAW stalls).
module seq_ctrl #(
    parameter int AW        = 5,
    parameter int LAST_ADDR = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [3:0]    dec_op,
    input  logic [2:0]    dec_rs,
    input  logic [2:0]    dec_rA,
    input  logic [2:0]    dec_rB,
    input  logic          dec_jz,
    input  logic [AW-1:0] dec_start,
    input  logic [AW-1:0] dec_end,
    output logic [AW-1:0] pc,
    output logic          ir_en,
    output logic          ex_kill,
    output logic          wb_en,
    output logic [2:0]    wb_sel,
    output logic          busy,
    output logic          halted,
`ifdef SEQ_CTRL_FWD_EN
    output logic          fwd_a,
    output logic          fwd_b,
`endif
    output logic [1:0]    dbg_state,
    output logic          dbg_loop_act
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_PASS = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [1:0]    state;
    logic          fill_cnt;
    logic          loop_act;
    logic [AW-1:0] ret;
    logic [AW-1:0] loop_end;
    logic [1:0]    kill_cnt;

    logic          slot_ok;
    logic          reads_a;
    logic          reads_b;
    logic          writes;
    logic          hit_a;
    logic          hit_b;
    logic          stall;
    logic          take_jz;
    logic          halt_now;
    logic          advance;
    logic [AW-1:0] pc_next;

    // Decode-slot qualification: a slot is live only in RUN once the post-jz squash window has drained.
    always_comb begin
        slot_ok  = (state == S_RUN) && (kill_cnt == 2'd0);
        reads_a  = !dec_jz && (dec_op != OP_NOP) && (dec_op != OP_HALT);
        reads_b  = reads_a && (dec_op != OP_PASS);
        writes   = reads_a;
        hit_a    = slot_ok && wb_en && reads_a && (dec_rA == wb_sel);
        hit_b    = slot_ok && wb_en && reads_b && (dec_rB == wb_sel);
        take_jz  = slot_ok && dec_jz && !loop_act;
        halt_now = slot_ok && !dec_jz && (dec_op == OP_HALT);
    end

`ifdef SEQ_CTRL_FWD_EN
    assign fwd_a = hit_a;
    assign fwd_b = hit_b;
    assign stall = 1'b0;
`else
    assign stall = hit_a || hit_b;
`endif

    // ir_en doubles as the ProgramMem read enable: when it is low the IR and the
    // memory output both hold, and the slot presented during that cycle is dropped
    // (ex_kill=1). A slot is acted on exactly when ex_kill=0.
    assign ir_en   = (state == S_FILL) || ((state == S_RUN) && !stall);
    assign ex_kill = !slot_ok || stall;
    assign busy    = (state == S_FILL) || (state == S_RUN);
    assign halted  = (state == S_HALTED);
    assign advance = (state == S_FILL) || ((state == S_RUN) && !stall && !halt_now);

    assign dbg_state    = state;
    assign dbg_loop_act = loop_act;

    always_comb begin
        pc_next = pc + AW'(1);
        if (take_jz) begin
            pc_next = dec_start;
        end else if (loop_act && (pc == loop_end)) begin
            pc_next = ret;
        end else if (pc == AW'(LAST_ADDR)) begin
            pc_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fill_cnt <= 1'b0;
            pc       <= '0;
            wb_en    <= 1'b0;
            wb_sel   <= 3'd0;
            loop_act <= 1'b0;
            ret      <= '0;
            loop_end <= '0;
            kill_cnt <= 2'd0;
        end else begin
            wb_en  <= slot_ok && !stall && writes;
            wb_sel <= dec_rs;
            if (kill_cnt != 2'd0) begin
                kill_cnt <= kill_cnt - 2'd1;
            end
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FILL;
                        fill_cnt <= 1'b0;
                    end
                end
                S_FILL: begin
                    fill_cnt <= 1'b1;
                    if (fill_cnt) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt_now) begin
                        state <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    // Restart from address 0 with any half-finished loop call forgotten.
                    if (run) begin
                        state    <= S_FILL;
                        fill_cnt <= 1'b0;
                        pc       <= '0;
                        loop_act <= 1'b0;
                        kill_cnt <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (advance) begin
                pc <= pc_next;
                if (take_jz) begin
                    ret      <= pc;
                    loop_end <= dec_end;
                    loop_act <= 1'b1;
                    kill_cnt <= 2'd2;
                end else if (loop_act && (pc == loop_end)) begin
                    loop_act <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed bench for seq_ctrl with a ProgramMem/IR model feeding the decode fields.
// Covers the default build (SEQ_CTRL_FWD_EN undefined).
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] dec_op;
    logic [2:0] dec_rs;
    logic [2:0] dec_rA;
    logic [2:0] dec_rB;
    logic       dec_jz;
    logic [4:0] dec_start;
    logic [4:0] dec_end;
    logic [4:0] pc;
    logic       ir_en;
    logic       ex_kill;
    logic       wb_en;
    logic [2:0] wb_sel;
    logic       busy;
    logic       halted;
    logic [1:0] dbg_state;
    logic       dbg_loop_act;
`ifdef SEQ_CTRL_FWD_EN
    logic       fwd_a;
    logic       fwd_b;
`endif

    int checks   = 0;
    int failures = 0;

    seq_ctrl #(.AW(5), .LAST_ADDR(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .dec_op       (dec_op),
        .dec_rs       (dec_rs),
        .dec_rA       (dec_rA),
        .dec_rB       (dec_rB),
        .dec_jz       (dec_jz),
        .dec_start    (dec_start),
        .dec_end      (dec_end),
        .pc           (pc),
        .ir_en        (ir_en),
        .ex_kill      (ex_kill),
        .wb_en        (wb_en),
        .wb_sel       (wb_sel),
        .busy         (busy),
        .halted       (halted),
`ifdef SEQ_CTRL_FWD_EN
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
`endif
        .dbg_state    (dbg_state),
        .dbg_loop_act (dbg_loop_act)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ProgramMem (sync read, enabled by ir_en) and IR model
    localparam logic [31:0] NOP_I = 32'h8000_0000;
    logic [31:0] prog [0:31];
    logic [31:0] mem_q;
    logic [31:0] ir;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= NOP_I;
            ir    <= NOP_I;
        end else if (ir_en) begin
            mem_q <= prog[pc];
            ir    <= mem_q;
        end
    end

    assign dec_op    = ir[31:28];
    assign dec_rs    = ir[27:25];
    assign dec_rA    = ir[24:22];
    assign dec_rB    = ir[21:19];
    assign dec_start = ir[14:10];
    assign dec_end   = ir[9:5];
    assign dec_jz    = ir[0];

    function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [2:0] rs, ra, rb);
        return {op, rs, ra, rb, 19'd0};
    endfunction

    function automatic logic [31:0] f_jz(input logic [4:0] s, e);
        return {4'b1000, 9'd0, 4'd0, s, e, 4'd0, 1'b1};
    endfunction

    // driver tasks
    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = NOP_I;
    endtask

    task automatic start_run();
        reset = 1'b0;
        @(negedge clk);
        run = 1'b1;
    endtask

    // scoreboard
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       run;
        logic [4:0] pc;
        logic       ir_en;
        logic       ex_kill;
        logic       wb_en;
        logic [2:0] wb_sel;
        logic       busy;
        logic       halted;
    } vec_t;

    function automatic vec_t row(input logic r, input logic [4:0] p, input logic ie, ek, we,
                                 input logic [2:0] ws, input logic b, h);
        vec_t v;
        v.run = r; v.pc = p; v.ir_en = ie; v.ex_kill = ek;
        v.wb_en = we; v.wb_sel = ws; v.busy = b; v.halted = h;
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {pc, ir_en, ex_kill, wb_en, wb_sel, busy, halted};
    endfunction

    localparam logic [12:0] RST_OUTS = {5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

    vec_t tbl [15];

    initial begin
        reset = 1'b1;
        run   = 1'b0;

        // Program A: ADD r2<=r0+r1; SUB r3<=r2-r1 (RAW on r2); NOP; NOP; ADD r4<=r5+r6; HALT
        clear_prog();
        prog[0] = f_alu(4'b0000, 3'd2, 3'd0, 3'd1);
        prog[1] = f_alu(4'b0001, 3'd3, 3'd2, 3'd1);
        prog[4] = f_alu(4'b0000, 3'd4, 3'd5, 3'd6);
        prog[5] = f_alu(4'b1111, 3'd0, 3'd0, 3'd0);

        //            run  pc  ie ek we ws  busy halt
        tbl[0]  = row(1, 5'd0, 0, 1, 0, 3'd0, 0, 0); // IDLE, run pulse
        tbl[1]  = row(1, 5'd0, 1, 1, 0, 3'd0, 1, 0); // FILL 1, run ignored
        tbl[2]  = row(0, 5'd1, 1, 1, 0, 3'd0, 1, 0); // FILL 2
        tbl[3]  = row(0, 5'd2, 1, 0, 0, 3'd0, 1, 0); // decode ADD r2
        tbl[4]  = row(0, 5'd3, 0, 1, 1, 3'd2, 1, 0); // SUB reads r2: stall
        tbl[5]  = row(0, 5'd3, 1, 0, 0, 3'd3, 1, 0); // stall released
        tbl[6]  = row(1, 5'd4, 1, 0, 1, 3'd3, 1, 0); // SUB writes back, run ignored
        tbl[7]  = row(0, 5'd5, 1, 0, 0, 3'd0, 1, 0);
        tbl[8]  = row(0, 5'd6, 1, 0, 0, 3'd0, 1, 0); // decode ADD r4
        tbl[9]  = row(0, 5'd7, 1, 0, 1, 3'd4, 1, 0); // HALT decoded, ADD r4 completes
        tbl[10] = row(0, 5'd7, 0, 1, 0, 3'd0, 0, 1); // HALTED, pc frozen
        tbl[11] = row(1, 5'd7, 0, 1, 0, 3'd0, 0, 1); // run from HALTED
        tbl[12] = row(0, 5'd0, 1, 1, 0, 3'd0, 1, 0); // restart at 0
        tbl[13] = row(0, 5'd1, 1, 1, 0, 3'd0, 1, 0);
        tbl[14] = row(0, 5'd2, 1, 0, 0, 3'd0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'(RST_OUTS));
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_loop_act", 32'(dbg_loop_act), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("tbl_row%0d", i), 32'(outs()),
                  32'({tbl[i].pc, tbl[i].ir_en, tbl[i].ex_kill, tbl[i].wb_en,
                       tbl[i].wb_sel, tbl[i].busy, tbl[i].halted}));
            run = tbl[i].run;
        end
        run = 1'b0;

        // Program B: jz at 4 calling 10..12, then straight NOPs through the 31->0 wrap
        reset = 1'b1;
        clear_prog();
        prog[4] = f_jz(5'd10, 5'd12);
        @(negedge clk);
        start_run();
        for (int a = 0; a <= 6; a++) exp_q.push_back(5'(a));
        exp_q.push_back(5'd10);
        exp_q.push_back(5'd11);
        exp_q.push_back(5'd12);
        for (int a = 6; a <= 31; a++) exp_q.push_back(5'(a));
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd1);
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            run = 1'b0;
            check($sformatf("jz_pc_c%0d", c), 32'(pc), 32'(exp_q.pop_front()));
            if (c == 6 || c == 9) check($sformatf("jz_kill_c%0d", c), 32'(ex_kill), 32'd0);
            if (c == 7 || c == 8) check($sformatf("jz_kill_c%0d", c), 32'(ex_kill), 32'd1);
            if (c == 9)  check("jz_loop_act_at_end", 32'(dbg_loop_act), 32'd1);
            if (c == 10) check("jz_loop_act_cleared", 32'(dbg_loop_act), 32'd0);
        end

        // Program C: async reset inside a loop body while a writeback is pending
        reset = 1'b1;
        clear_prog();
        prog[2] = f_jz(5'd8, 5'd14);
        prog[8] = f_alu(4'b0000, 3'd5, 3'd0, 3'd0);
        @(negedge clk);
        start_run();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            run = 1'b0;
        end
        check("mid_pc", 32'(pc), 32'd11);
        check("mid_wb_en", 32'(wb_en), 32'd1);
        check("mid_wb_sel", 32'(wb_sel), 32'd5);
        check("mid_loop_act", 32'(dbg_loop_act), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outs", 32'(outs()), 32'(RST_OUTS));
        check("async_rst_loop_act", 32'(dbg_loop_act), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        check("rst_held_outs", 32'(outs()), 32'(RST_OUTS));
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(outs()), 32'(RST_OUTS));

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
